// File: rtl/fifo_pack_if.sv
// fifo_pack_if: upstream FIFO read side plus packed-beat output handshake.
// master = the packer, slave = the surrounding FIFO / downstream logic.
// out_mask exists only when FIFO_PACK_PARTIAL_EN is defined.
interface fifo_pack_if #(
  parameter int WIDTH = 16,
  parameter int RATIO = 2
);
  logic                   fifo_empty;
  logic [WIDTH-1:0]       fifo_rdata;
  logic                   fifo_pop;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH*RATIO-1:0] out_data;
`ifdef FIFO_PACK_PARTIAL_EN
  logic [RATIO-1:0]       out_mask;

  modport master (
    input  fifo_empty, fifo_rdata, flush, out_ready,
    output fifo_pop, out_valid, out_data, out_mask
  );

  modport slave (
    output fifo_empty, fifo_rdata, flush, out_ready,
    input  fifo_pop, out_valid, out_data, out_mask
  );
`else
  modport master (
    input  fifo_empty, fifo_rdata, flush, out_ready,
    output fifo_pop, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_rdata, flush, out_ready,
    input  fifo_pop, out_valid, out_data
  );
`endif
endinterface

// File: rtl/fifo_pack.sv
// fifo_pack: pops WIDTH-bit words from a zero-latency FIFO and packs RATIO of
// them into one output beat, first word in the lowest lane.
// Optional feature macro: FIFO_PACK_PARTIAL_EN -- flush emits a zero-padded
// partial beat with a lane mask; without it a flush drops the partial words.
module fifo_pack #(
  parameter int WIDTH = 16,
  parameter int RATIO = 2
) (
  input logic         clk,
  input logic         rst,
  fifo_pack_if.master bus
);
  localparam int            CW   = $clog2(RATIO);
  localparam int            DW   = WIDTH * RATIO;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  typedef enum logic [1:0] {ACCUM, READY, STALL} state_t;

  state_t        state;
  logic [DW-1:0] acc_reg, acc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] data_reg, data_next;
  logic          out_valid_reg, out_valid_next;
  logic          pop;
`ifdef FIFO_PACK_PARTIAL_EN
  logic [RATIO-1:0] mask_reg, mask_next;
  logic             pend_reg, pend_next;
  logic [CW:0]      filled;

  // Lanes that would be occupied after this cycle's pop
  assign filled = {1'b0, cnt_reg} + {{CW{1'b0}}, pop};
`endif

  // Output-side state: no beat, beat held, or beat held while the last lane waits on it
  always_comb begin
    state = ACCUM;
    if (out_valid_reg) begin
      if (cnt_reg == LAST && !bus.out_ready) state = STALL;
      else                                   state = READY;
    end
  end

  // Pop whenever a word is offered unless the last lane has nowhere to go
  assign pop = !rst && !bus.fifo_empty && (state != STALL);

  // Next-state: lane capture, beat load, handshake drain and flush handling
  always_comb begin
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    data_next      = data_reg;
    out_valid_next = out_valid_reg;
`ifdef FIFO_PACK_PARTIAL_EN
    mask_next      = mask_reg;
    pend_next      = pend_reg;
`endif
    if (out_valid_reg && bus.out_ready) out_valid_next = 1'b0;
    for (int i = 0; i < RATIO; i++) begin
      if (pop && cnt_reg == CW'(i)) acc_next[i*WIDTH +: WIDTH] = bus.fifo_rdata;
    end
    if (pop) cnt_next = cnt_reg + 1'b1;

    if (pop && cnt_reg == LAST) begin
      // Full beat; the accumulator is cleared so later partial beats pad with zeros
      data_next      = acc_next;
      out_valid_next = 1'b1;
      cnt_next       = '0;
      acc_next       = '0;
`ifdef FIFO_PACK_PARTIAL_EN
      mask_next      = '1;
      pend_next      = 1'b0;
`endif
    end
`ifdef FIFO_PACK_PARTIAL_EN
    else if (bus.flush || pend_reg) begin
      if (filled == '0) begin
        pend_next = 1'b0;
      end else if (state == ACCUM || bus.out_ready) begin
        // Output register is free or draining this cycle: close the partial beat now
        data_next      = acc_next;
        out_valid_next = 1'b1;
        cnt_next       = '0;
        acc_next       = '0;
        pend_next      = 1'b0;
        for (int i = 0; i < RATIO; i++) mask_next[i] = (i < int'(filled));
      end else begin
        // Output register still blocked: remember the flush and keep accumulating
        pend_next = 1'b1;
      end
    end
`else
    else if (bus.flush) begin
      // Drop the partial words (including any popped this cycle); a held beat is untouched
      cnt_next = '0;
      acc_next = '0;
    end
`endif
  end

  // State register; reset clears everything immediately, without waiting for clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      data_reg      <= '0;
      out_valid_reg <= 1'b0;
`ifdef FIFO_PACK_PARTIAL_EN
      mask_reg      <= '0;
      pend_reg      <= 1'b0;
`endif
    end else begin
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      data_reg      <= data_next;
      out_valid_reg <= out_valid_next;
`ifdef FIFO_PACK_PARTIAL_EN
      mask_reg      <= mask_next;
      pend_reg      <= pend_next;
`endif
    end
  end

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = data_reg;
`ifdef FIFO_PACK_PARTIAL_EN
  assign bus.out_mask  = mask_reg;
`endif
endmodule

// File: tb/tb_fifo_pack.sv
// tb_fifo_pack: directed and randomized checks of fifo_pack.
// u_dut2 (RATIO=2) carries most scenarios, u_dut4 (RATIO=4) the flush cases.
// Builds with or without FIFO_PACK_PARTIAL_EN.
module tb_fifo_pack;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fifo_pack_if #(.WIDTH(W), .RATIO(2)) bus2 ();
  fifo_pack_if #(.WIDTH(W), .RATIO(4)) bus4 ();

  fifo_pack #(.WIDTH(W), .RATIO(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  fifo_pack #(.WIDTH(W), .RATIO(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Reference model for u_dut2: words waiting for a beat, plus the output slot
  logic [W-1:0]   m_acc [$];
  logic           m_valid;
  logic [2*W-1:0] m_data;
  logic [1:0]     m_mask;
  logic           m_pend;

  task automatic m_reset();
    m_acc.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_mask  = '0;
    m_pend  = 1'b0;
  endtask

  function automatic logic m_pop(input logic empty, input logic ready);
    return !empty && !(m_acc.size() == 1 && m_valid && !ready);
  endfunction

  function automatic logic [2*W-1:0] m_pack();
    logic [2*W-1:0] d;
    d = '0;
    for (int i = 0; i < m_acc.size(); i++) d[i*W +: W] = m_acc[i];
    return d;
  endfunction

  // Advance the model by one clock given this cycle's inputs
  task automatic m_step(input logic empty, input logic [W-1:0] rdata,
                        input logic ready, input logic flush);
    logic popped;
    logic free;
    logic load;
    popped = m_pop(empty, ready);
    free   = !m_valid || ready;
    load   = 1'b0;
    if (m_valid && ready) m_valid = 1'b0;
    if (popped) m_acc.push_back(rdata);
    if (m_acc.size() == 2) begin
      m_data = m_pack();
      m_mask = 2'b11;
      m_acc.delete();
      m_pend = 1'b0;
      load   = 1'b1;
    end else if (flush || m_pend) begin
`ifdef FIFO_PACK_PARTIAL_EN
      if (m_acc.size() == 0) begin
        m_pend = 1'b0;
      end else if (free) begin
        m_data = m_pack();
        m_mask = 2'((1 << m_acc.size()) - 1);
        m_acc.delete();
        m_pend = 1'b0;
        load   = 1'b1;
      end else begin
        m_pend = 1'b1;
      end
`else
      m_acc.delete();
`endif
    end
    if (load) m_valid = 1'b1;
  endtask

  task automatic idle_inputs();
    bus2.fifo_empty = 1'b1; bus2.fifo_rdata = '0; bus2.flush = 1'b0; bus2.out_ready = 1'b0;
    bus4.fifo_empty = 1'b1; bus4.fifo_rdata = '0; bus4.flush = 1'b0; bus4.out_ready = 1'b0;
  endtask

  // Called just after a rising edge; returns before the next falling edge
  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus2.fifo_empty = 1'b0; bus2.fifo_rdata = 16'hFFFF;
    bus4.fifo_empty = 1'b0; bus4.fifo_rdata = 16'hFFFF;
    @(negedge clk);
    checks++; if (bus2.fifo_pop !== 1'b0) begin failures++; $display("FAIL reset_pop2 got=%b want=0", bus2.fifo_pop); end
    checks++; if (bus4.fifo_pop !== 1'b0) begin failures++; $display("FAIL reset_pop4 got=%b want=0", bus4.fifo_pop); end
    checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid2 got=%b want=0", bus2.out_valid); end
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid4 got=%b want=0", bus4.out_valid); end
    checks++; if (bus2.out_data !== 32'h0) begin failures++; $display("FAIL reset_data2 got=%h want=0", bus2.out_data); end
    checks++; if (bus4.out_data !== 64'h0) begin failures++; $display("FAIL reset_data4 got=%h want=0", bus4.out_data); end
`ifdef FIFO_PACK_PARTIAL_EN
    checks++; if (bus4.out_mask !== 4'b0) begin failures++; $display("FAIL reset_mask4 got=%b want=0", bus4.out_mask); end
`endif
    @(posedge clk); #1;
    checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL reset_edge_valid2 got=%b want=0", bus2.out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (bus2.fifo_pop !== 1'b1) begin failures++; $display("FAIL release_pop2 got=%b want=1", bus2.fifo_pop); end
    idle_inputs();
    m_reset();
    $display("tb: reset done");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   words [4];
    logic [2*W-1:0] exp_d;
    logic           exp_p;
    logic           exp_v;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    apply_reset();
    bus2.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus2.fifo_empty = (c >= 4);
      bus2.fifo_rdata = (c < 4) ? words[c] : '0;
      exp_p = (c < 4);
      exp_v = (c == 2) || (c == 4);
      @(negedge clk);
      checks++; if (bus2.fifo_pop !== exp_p) begin failures++; $display("FAIL b2b_pop cycle=%0d got=%b want=%b", c, bus2.fifo_pop, exp_p); end
      checks++; if (bus2.out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid cycle=%0d got=%b want=%b", c, bus2.out_valid, exp_v); end
      if (exp_v) begin
        exp_d = (c == 2) ? 32'h22221111 : 32'h44443333;
        checks++; if (bus2.out_data !== exp_d) begin failures++; $display("FAIL b2b_data cycle=%0d got=%h want=%h", c, bus2.out_data, exp_d); end
        $display("tb: b2b beat data=%h", exp_d);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]   w [5];
    logic [7:0]     t_pop;
    logic [7:0]     t_rdy;
    logic [7:0]     t_val;
    logic [2*W-1:0] exp_d;
    int             idx;
    apply_reset();
    // per-cycle tables, bit c = cycle c
    t_pop = 8'b0110_0111;
    t_rdy = 8'b1110_0011;
    t_val = 8'b0111_1100;
    foreach (w[i]) w[i] = W'($urandom);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus2.fifo_empty = (idx >= 5);
      bus2.fifo_rdata = (idx < 5) ? w[idx] : '0;
      bus2.out_ready  = t_rdy[c];
      @(negedge clk);
      checks++; if (bus2.fifo_pop !== t_pop[c]) begin failures++; $display("FAIL bp_pop cycle=%0d got=%b want=%b", c, bus2.fifo_pop, t_pop[c]); end
      checks++; if (bus2.out_valid !== t_val[c]) begin failures++; $display("FAIL bp_valid cycle=%0d got=%b want=%b", c, bus2.out_valid, t_val[c]); end
      if (t_val[c]) begin
        exp_d = (c < 6) ? {w[1], w[0]} : {w[3], w[2]};
        checks++; if (bus2.out_data !== exp_d) begin failures++; $display("FAIL bp_data cycle=%0d got=%h want=%h", c, bus2.out_data, exp_d); end
        if (t_rdy[c]) $display("tb: bp beat data=%h", exp_d);
      end
      if (t_pop[c]) idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_starved();
    logic [W-1:0] head;
    logic         e;
    logic         exp_p;
    apply_reset();
    bus2.out_ready = 1'b1;
    head = W'($urandom);
    for (int c = 0; c < 12; c++) begin
      e = (c % 2 == 1);
      bus2.fifo_empty = e;
      bus2.fifo_rdata = head;
      @(negedge clk);
      exp_p = m_pop(e, 1'b1);
      checks++; if (bus2.fifo_pop !== exp_p) begin failures++; $display("FAIL starve_pop cycle=%0d got=%b want=%b", c, bus2.fifo_pop, exp_p); end
      checks++; if (bus2.out_valid !== m_valid) begin failures++; $display("FAIL starve_valid cycle=%0d got=%b want=%b", c, bus2.out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (bus2.out_data !== m_data) begin failures++; $display("FAIL starve_data cycle=%0d got=%h want=%h", c, bus2.out_data, m_data); end
        $display("tb: starve beat data=%h", m_data);
      end
      m_step(e, head, 1'b1, 1'b0);
      if (exp_p) head = W'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_partial_flush();
    logic [W-1:0]   w4 [4];
    logic [4*W-1:0] exp_d;
    apply_reset();
    foreach (w4[i]) w4[i] = W'($urandom);
    bus4.out_ready  = 1'b1;
    bus4.fifo_empty = 1'b0;
    bus4.fifo_rdata = 16'hABCD;
    @(negedge clk);
    checks++; if (bus4.fifo_pop !== 1'b1) begin failures++; $display("FAIL pf_pop got=%b want=1", bus4.fifo_pop); end
    @(posedge clk); #1;
    bus4.fifo_empty = 1'b1;
    bus4.flush      = 1'b1;
    @(negedge clk);
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL pf_early_valid got=%b want=0", bus4.out_valid); end
    @(posedge clk); #1;
    bus4.flush = 1'b0;
    @(negedge clk);
`ifdef FIFO_PACK_PARTIAL_EN
    checks++; if (bus4.out_valid !== 1'b1) begin failures++; $display("FAIL pf_valid got=%b want=1", bus4.out_valid); end
    checks++; if (bus4.out_data !== 64'h0000_0000_0000_ABCD) begin failures++; $display("FAIL pf_data got=%h want=000000000000abcd", bus4.out_data); end
    checks++; if (bus4.out_mask !== 4'b0001) begin failures++; $display("FAIL pf_mask got=%b want=0001", bus4.out_mask); end
    $display("tb: pf partial beat data=%h", bus4.out_data);
`else
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL pf_nobeat got=%b want=0", bus4.out_valid); end
`endif
    @(posedge clk); #1;
    // four fresh words must form a beat on their own: lane counter restarted at zero
    for (int i = 0; i < 4; i++) begin
      bus4.fifo_empty = 1'b0;
      bus4.fifo_rdata = w4[i];
      @(negedge clk);
      checks++; if (bus4.fifo_pop !== 1'b1) begin failures++; $display("FAIL pf_fill_pop word=%0d got=%b want=1", i, bus4.fifo_pop); end
      @(posedge clk); #1;
    end
    bus4.fifo_empty = 1'b1;
    exp_d = {w4[3], w4[2], w4[1], w4[0]};
    @(negedge clk);
    checks++; if (bus4.out_valid !== 1'b1) begin failures++; $display("FAIL pf_full_valid got=%b want=1", bus4.out_valid); end
    checks++; if (bus4.out_data !== exp_d) begin failures++; $display("FAIL pf_full_data got=%h want=%h", bus4.out_data, exp_d); end
`ifdef FIFO_PACK_PARTIAL_EN
    checks++; if (bus4.out_mask !== 4'b1111) begin failures++; $display("FAIL pf_full_mask got=%b want=1111", bus4.out_mask); end
`endif
    $display("tb: pf full beat data=%h", exp_d);
    @(posedge clk); #1;
    // flush in the same cycle as the first pop: that word alone is the beat
    bus4.fifo_empty = 1'b0;
    bus4.fifo_rdata = 16'h1234;
    bus4.flush      = 1'b1;
    @(negedge clk);
    checks++; if (bus4.fifo_pop !== 1'b1) begin failures++; $display("FAIL pf_same_pop got=%b want=1", bus4.fifo_pop); end
    @(posedge clk); #1;
    bus4.fifo_empty = 1'b1;
    bus4.flush      = 1'b0;
    @(negedge clk);
`ifdef FIFO_PACK_PARTIAL_EN
    checks++; if (bus4.out_valid !== 1'b1) begin failures++; $display("FAIL pf_same_valid got=%b want=1", bus4.out_valid); end
    checks++; if (bus4.out_data !== 64'h0000_0000_0000_1234) begin failures++; $display("FAIL pf_same_data got=%h want=0000000000001234", bus4.out_data); end
    checks++; if (bus4.out_mask !== 4'b0001) begin failures++; $display("FAIL pf_same_mask got=%b want=0001", bus4.out_mask); end
    $display("tb: pf same-cycle beat data=%h", bus4.out_data);
`else
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL pf_same_nobeat got=%b want=0", bus4.out_valid); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] wa [3];
    logic [W-1:0] wb [2];
    foreach (wa[i]) wa[i] = W'($urandom);
    foreach (wb[i]) wb[i] = W'($urandom);
    apply_reset();
    bus2.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus2.fifo_empty = 1'b0;
      bus2.fifo_rdata = wa[i];
      @(negedge clk);
      checks++; if (bus2.fifo_pop !== 1'b1) begin failures++; $display("FAIL rm_pop word=%0d got=%b want=1", i, bus2.fifo_pop); end
      @(posedge clk); #1;
    end
    bus2.fifo_rdata = wb[0];
    @(negedge clk);
    checks++; if (bus2.fifo_pop !== 1'b0) begin failures++; $display("FAIL rm_stall_pop got=%b want=0", bus2.fifo_pop); end
    checks++; if (bus2.out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%b want=1", bus2.out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL rm_async_valid got=%b want=0", bus2.out_valid); end
    checks++; if (bus2.out_data !== 32'h0) begin failures++; $display("FAIL rm_async_data got=%h want=0", bus2.out_data); end
    checks++; if (bus2.fifo_pop !== 1'b0) begin failures++; $display("FAIL rm_gate_pop got=%b want=0", bus2.fifo_pop); end
    rst = 1'b0;
    #1;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus2.fifo_rdata = wb[i];
      @(negedge clk);
      checks++; if (bus2.fifo_pop !== 1'b1) begin failures++; $display("FAIL rm_post_pop word=%0d got=%b want=1", i, bus2.fifo_pop); end
      checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL rm_post_valid word=%0d got=%b want=0", i, bus2.out_valid); end
      @(posedge clk); #1;
    end
    bus2.fifo_empty = 1'b1;
    @(negedge clk);
    checks++; if (bus2.out_valid !== 1'b1) begin failures++; $display("FAIL rm_beat_valid got=%b want=1", bus2.out_valid); end
    checks++; if (bus2.out_data !== {wb[1], wb[0]}) begin failures++; $display("FAIL rm_beat_data got=%h want=%h", bus2.out_data, {wb[1], wb[0]}); end
    $display("tb: rm beat data=%h", {wb[1], wb[0]});
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] head;
    logic         e;
    logic         r;
    logic         f;
    logic         exp_p;
    apply_reset();
    head = W'($urandom);
    for (int c = 0; c < 200; c++) begin
      e = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) == 0);
      bus2.fifo_empty = e;
      bus2.fifo_rdata = head;
      bus2.out_ready  = r;
      bus2.flush      = f;
      @(negedge clk);
      exp_p = m_pop(e, r);
      checks++; if (bus2.fifo_pop !== exp_p) begin failures++; $display("FAIL rnd_pop cycle=%0d got=%b want=%b", c, bus2.fifo_pop, exp_p); end
      checks++; if (bus2.out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid cycle=%0d got=%b want=%b", c, bus2.out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (bus2.out_data !== m_data) begin failures++; $display("FAIL rnd_data cycle=%0d got=%h want=%h", c, bus2.out_data, m_data); end
`ifdef FIFO_PACK_PARTIAL_EN
        checks++; if (bus2.out_mask !== m_mask) begin failures++; $display("FAIL rnd_mask cycle=%0d got=%b want=%b", c, bus2.out_mask, m_mask); end
`endif
        if (r) $display("tb: rnd beat cycle=%0d data=%h mask=%b", c, m_data, m_mask);
      end
      m_step(e, head, r, f);
      if (exp_p) head = W'($urandom);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_reset();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_starved();
    test_partial_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end
endmodule
